// File: rtl/uart_rx_line_mon.sv
// uart_rx_line_mon: 16x-oversampled UART receiver feeding a line assembler.
// Bytes are gathered into a line buffer that closes on 0x0A or when full.
// Each finished line is offered to a consumer over valid/ready, and the
// consumer reads it back through a registered, indexed read port.
// Optional build macro: UART_RX_LINE_MON_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit. Without it, frames are 8N1.
module uart_rx_line_mon #(
    parameter int Divisor = 5,
    parameter int LineLen = 80,
    parameter int IdxW    = $clog2(LineLen + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_i,
    output logic            byte_valid_o,
    output logic [7:0]      byte_o,
    output logic            line_valid_o,
    input  logic            line_ready_i,
    output logic [IdxW-1:0] line_len_o,
    input  logic [IdxW-1:0] rd_idx_i,
    output logic [7:0]      rd_data_o,
    output logic            frame_err_o,
    output logic            parity_err_o,
    output logic            overflow_o
);

    localparam int TICK_W = (Divisor > 1) ? $clog2(Divisor) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX   = TICK_W'(Divisor - 1);
    localparam logic [IdxW-1:0]   LINE_LEN_W = IdxW'(LineLen);

`ifdef UART_RX_LINE_MON_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    // ---------------------------------------------------------------
    // Input synchronizer and edge detector
    // ---------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_rx_fall;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // ---------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------
    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [3:0]        r_samp;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              r_byte_valid;
    logic [7:0]        r_byte;
    logic              r_frame_err;
`ifdef UART_RX_LINE_MON_PARITY_EN
    logic              r_par_bad;
    logic              r_parity_err;
`endif
    logic              w_tick_done;
    logic              w_mid_start;
    logic              w_mid_bit;

    assign w_tick_done = (r_tick == TICK_MAX);
    // Start bit is checked half a bit in; every later bit is 16 samples on
    assign w_mid_start = w_tick_done && (r_samp == 4'd7);
    assign w_mid_bit   = w_tick_done && (r_samp == 4'd15);

    // Frame decoder: counters, bit sampling and registered result pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_samp       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_LINE_MON_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_LINE_MON_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // Counters idle at zero so a new frame always starts aligned
            if (r_state == S_IDLE) begin
                r_tick <= '0;
                r_samp <= '0;
            end else begin
                r_tick <= w_tick_done ? '0 : r_tick + 1'b1;
                if (w_tick_done) begin
                    r_samp <= r_samp + 4'd1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rx_fall) begin
                        r_state <= S_START;
                        r_bit   <= '0;
                    end
                end
                S_START: begin
                    if (w_mid_start) begin
                        // Re-align the sample counter to mid-bit
                        r_samp  <= '0;
                        r_state <= r_rx_sync ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_mid_bit) begin
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
`ifdef UART_RX_LINE_MON_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_LINE_MON_PARITY_EN
                S_PARITY: begin
                    if (w_mid_bit) begin
                        // Even parity: parity bit must equal XOR of data bits
                        r_par_bad <= (r_rx_sync != ^r_shift);
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (w_mid_bit) begin
                        r_state <= S_IDLE;
                        if (!r_rx_sync) begin
                            r_frame_err <= 1'b1;
                        end
`ifdef UART_RX_LINE_MON_PARITY_EN
                        if (r_par_bad) begin
                            r_parity_err <= 1'b1;
                        end
                        if (r_rx_sync && !r_par_bad) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end
`else
                        if (r_rx_sync) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_valid_o = r_byte_valid;
    assign byte_o       = r_byte;
    assign frame_err_o  = r_frame_err;
`ifdef UART_RX_LINE_MON_PARITY_EN
    assign parity_err_o = r_parity_err;
`else
    assign parity_err_o = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Line assembler
    // ---------------------------------------------------------------
    logic [7:0]      r_mem [LineLen];
    logic [IdxW-1:0] r_count;
    logic [IdxW-1:0] r_line_len;
    logic            r_line_valid;
    logic            r_overflow;
    logic [7:0]      r_rd_data;

    logic            w_hs;
    logic            w_accept;
    logic            w_is_nl;
    logic            w_wr_en;
    logic [IdxW-1:0] w_base;
    logic [IdxW-1:0] w_next_cnt;
    logic            w_full;
    logic [IdxW-1:0] w_rd_addr;

    assign w_hs       = r_line_valid & line_ready_i;
    // A byte is usable unless a line is held and not being released now
    assign w_accept   = r_byte_valid & (~r_line_valid | line_ready_i);
    // A handshake in the same cycle means the byte starts the new line
    assign w_base     = w_hs ? '0 : r_count;
    assign w_is_nl    = (r_byte == 8'h0A);
    assign w_wr_en    = w_accept & ~w_is_nl;
    assign w_next_cnt = w_base + IdxW'(1);
    assign w_full     = (w_next_cnt == LINE_LEN_W);
    // Out-of-range reads fold onto entry 0 so the result stays stable
    assign w_rd_addr  = (rd_idx_i < LINE_LEN_W) ? rd_idx_i : '0;

    // Line control: fill count, close on newline or full, release on handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count      <= '0;
            r_line_len   <= '0;
            r_line_valid <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_hs) begin
                r_line_valid <= 1'b0;
                r_count      <= '0;
            end
            if (r_byte_valid && r_line_valid && !line_ready_i) begin
                r_overflow <= 1'b1;
            end
            if (w_accept) begin
                if (w_is_nl) begin
                    r_line_valid <= 1'b1;
                    r_line_len   <= w_base;
                    r_count      <= '0;
                end else if (w_full) begin
                    r_line_valid <= 1'b1;
                    r_line_len   <= w_next_cnt;
                    r_count      <= '0;
                end else begin
                    r_count <= w_next_cnt;
                end
            end
        end
    end

    // Buffer write port; storage itself is not reset
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_base] <= r_byte;
        end
    end

    // Registered read port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    assign line_valid_o = r_line_valid;
    assign line_len_o   = r_line_len;
    assign rd_data_o    = r_rd_data;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_uart_rx_line_mon.sv
// Self-checking bench for uart_rx_line_mon (Divisor=5, LineLen=80).
// Frames are driven on the falling clock edge, outputs are sampled there too.
module tb_uart_rx_line_mon;

    localparam int BIT = 80;
    localparam int GAP = 8;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       byte_valid;
    logic [7:0] byte_d;
    logic       line_valid;
    logic       line_ready;
    logic [6:0] line_len;
    logic [6:0] rd_idx;
    logic [7:0] rd_data;
    logic       frame_err;
    logic       parity_err;
    logic       overflow;

    uart_rx_line_mon dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_i         (rx),
        .byte_valid_o (byte_valid),
        .byte_o       (byte_d),
        .line_valid_o (line_valid),
        .line_ready_i (line_ready),
        .line_len_o   (line_len),
        .rd_idx_i     (rd_idx),
        .rd_data_o    (rd_data),
        .frame_err_o  (frame_err),
        .parity_err_o (parity_err),
        .overflow_o   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts every pulse, including any during reset
    int         bv_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    int         last_bv_cyc = 0;
    always @(negedge clk) begin
        if (byte_valid) begin
            bv_cnt      = bv_cnt + 1;
            last_byte   = byte_d;
            last_bv_cyc = cyc;
        end
        if (frame_err)  ferr_cnt = ferr_cnt + 1;
        if (parity_err) perr_cnt = perr_cnt + 1;
    end

    int n_pass = 0;
    int n_tot  = 0;
    int stop_cyc = 0;
`ifdef UART_RX_LINE_MON_PARITY_EN
    logic tx_par_flip = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot = n_tot + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
`ifdef UART_RX_LINE_MON_PARITY_EN
        rx = (^d) ^ tx_par_flip;
        repeat (BIT) @(negedge clk);
`endif
        stop_cyc = cyc;
        rx = stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] idx, input logic [7:0] exp);
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        chk(name, {24'h0, rd_data}, {24'h0, exp});
    endtask

    // Accept the held line and confirm line_valid drops one cycle later
    task automatic consume(input string name);
        @(negedge clk);
        line_ready = 1'b1;
        @(negedge clk);
        line_ready = 1'b0;
        chk(name, {31'h0, line_valid}, 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_bv;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int b0;
        int f0;
        int p0;
        vecs[0] = '{8'h48, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h69, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h0A, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h41, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; rx = 1'b1; line_ready = 1'b0; rd_idx = '0;
        repeat (4) @(negedge clk);
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'd0);
        chk("rst_line_valid", {31'h0, line_valid}, 32'd0);
        chk("rst_line_len",   {25'h0, line_len},   32'd0);
        chk("rst_byte",       {24'h0, byte_d},     32'd0);
        chk("rst_rd_data",    {24'h0, rd_data},    32'd0);
        chk("rst_errs",       {30'h0, frame_err, parity_err}, 32'd0);
        chk("rst_overflow",   {31'h0, overflow},   32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Test 1 ("Hi\n") and test 2 (bad stop bit then 0x41) from the table
        for (int v = 0; v < 5; v++) begin
            b0 = bv_cnt; f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop);
            $display("frame %0d data=0x%02h stop=%0b bv=%0d ferr=%0d", v, vecs[v].data,
                     vecs[v].stop, bv_cnt - b0, ferr_cnt - f0);
            chk($sformatf("v%0d_bv_count", v), bv_cnt - b0, {31'h0, vecs[v].exp_bv});
            chk($sformatf("v%0d_ferr_count", v), ferr_cnt - f0, {31'h0, vecs[v].exp_ferr});
            if (vecs[v].exp_bv) begin
                chk($sformatf("v%0d_byte", v), {24'h0, last_byte}, {24'h0, vecs[v].data});
                chk($sformatf("v%0d_latency_ok", v),
                    {31'h0, ((last_bv_cyc - stop_cyc) >= 40) && ((last_bv_cyc - stop_cyc) <= 44)}, 32'd1);
            end
            if (v == 2) begin
                chk("hi_line_valid", {31'h0, line_valid}, 32'd1);
                chk("hi_line_len", {25'h0, line_len}, 32'd2);
                rd_chk("hi_rd0", 7'd0, 8'h48);
                rd_chk("hi_rd1", 7'd1, 8'h69);
                consume("hi_consume");
            end
        end
        // 0x41 was stored; close with newline
        send_frame(8'h0A, 1'b1);
        chk("a_line_len", {25'h0, line_len}, 32'd1);
        rd_chk("a_rd0", 7'd0, 8'h41);
        consume("a_consume");

        // Test 3: 30-cycle glitch low is a false start
        b0 = bv_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        @(negedge clk); rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (200) @(negedge clk);
        chk("false_start_pulses", (bv_cnt - b0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);
        send_frame(8'h0A, 1'b1);
        chk("false_start_recover_lv", {31'h0, line_valid}, 32'd1);
        chk("false_start_recover_len", {25'h0, line_len}, 32'd0);
        consume("fs_consume");

        // Test 5: reset in bit 4 of 0x3C with one byte already buffered
        send_frame(8'h5A, 1'b1);
        b0 = bv_cnt; f0 = ferr_cnt; p0 = perr_cnt;
        @(negedge clk); rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i >= 2) ? 1'b1 : 1'b0;
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (BIT * 8) @(negedge clk);
        chk("rst_mid_pulses", (bv_cnt - b0) + (ferr_cnt - f0) + (perr_cnt - p0), 32'd0);
        chk("rst_mid_line_valid", {31'h0, line_valid}, 32'd0);
        send_frame(8'h0A, 1'b1);
        chk("rst_mid_lv", {31'h0, line_valid}, 32'd1);
        chk("rst_mid_len", {25'h0, line_len}, 32'd0);
        consume("rst_consume");
        chk("pre_ovf", {31'h0, overflow}, 32'd0);

        // Test 4: 81 bytes with ready low
        b0 = bv_cnt;
        for (int n = 1; n <= 81; n++) begin
            send_frame(8'h41, 1'b1);
            if (n == 79) chk("fill79_lv", {31'h0, line_valid}, 32'd0);
            if (n == 80) begin
                chk("fill80_lv", {31'h0, line_valid}, 32'd1);
                chk("fill80_len", {25'h0, line_len}, 32'd80);
                chk("fill80_ovf", {31'h0, overflow}, 32'd0);
            end
        end
        $display("fill done bv=%0d lv=%0b len=%0d ovf=%0b", bv_cnt - b0, line_valid, line_len, overflow);
        chk("fill81_bv_count", bv_cnt - b0, 32'd81);
        chk("fill81_ovf", {31'h0, overflow}, 32'd1);
        chk("fill81_len", {25'h0, line_len}, 32'd80);
        rd_chk("fill_rd79", 7'd79, 8'h41);
        rd_chk("fill_rd0", 7'd0, 8'h41);
        consume("fill_consume");
        chk("ovf_sticky", {31'h0, overflow}, 32'd1);

`ifdef UART_RX_LINE_MON_PARITY_EN
        // Test 6: wrong then right even parity on 0x07
        b0 = bv_cnt; p0 = perr_cnt;
        tx_par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        tx_par_flip = 1'b0;
        chk("par_bad_perr", perr_cnt - p0, 32'd1);
        chk("par_bad_bv", bv_cnt - b0, 32'd0);
        b0 = bv_cnt;
        send_frame(8'h07, 1'b1);
        chk("par_ok_bv", bv_cnt - b0, 32'd1);
        chk("par_ok_byte", {24'h0, last_byte}, 32'h07);
        send_frame(8'h0A, 1'b1);
        chk("par_line_len", {25'h0, line_len}, 32'd1);
        rd_chk("par_rd0", 7'd0, 8'h07);
`else
        chk("no_parity_pulses", perr_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
